present80_dec: RTL
==================

Name: present80_dec

Overview:
- PRESENT-80 block decryption core: 64-bit ciphertext block, 80-bit key, 64-bit plaintext out.
- Inverse companion to the PRESENT encryption path; same load/done style, so the two can sit side by side in the crypto wrapper.
- Iterative, one round per clock.
- On-the-fly key schedule: expands forward to the last round key K32, then walks the schedule backwards during decryption.

Parameters:
- NR, 31, number of full rounds. Only 31 is a conformant PRESENT-80; smaller values are for reduced-round debug only.

Ports:
- clk    input   1   rising-edge clock
- reset  input   1   asynchronous, active-high reset
- idat   input   64  ciphertext, sampled on load
- key    input   80  cipher key, sampled on load
- load   input   1   start request, single-cycle
- odat   output  64  plaintext, valid when done=1 and held afterwards
- done   output  1   one-cycle pulse when odat is updated
- busy   output  1   high from the cycle after an accepted load until done

Behaviour:
- Reset (async, active-high):
  - state=IDLE; odat=0; done=0; busy=0.
  - Internal kreg, dreg and round counter all cleared.
  - Reset mid-operation aborts the operation; no done is produced.
- States: IDLE -> KEYEXP -> DEC -> FIN -> IDLE.
- Load acceptance:
  - load is accepted in any state; a load while busy aborts and restarts.
  - Accepting load latches dreg<=idat and kreg<=key, sets rc=1, clears odat to 0, and enters KEYEXP.
  - busy goes to 1 at the same edge.
- KEYEXP (NR cycles), forward key update applied each cycle:
  - rotate left 61;
  - S-box on bits [79:76];
  - bits [19:15] ^= rc (5 bits);
  - rc++.
  - After NR cycles kreg=K(NR+1) and rc=NR. Enter DEC.
- DEC (NR cycles, rc counts NR down to 1), each cycle:
  - dreg <= invS(invP(dreg ^ kreg[79:64+...])), i.e. dreg ^ kreg[79:16], then inverse pLayer, then inverse S-box on all 16 nibbles.
  - kreg <= inverse key update:
    - bits [19:15] ^= rc;
    - inverse S-box on bits [79:76];
    - rotate right 61.
  - rc--.
  - After the rc=1 step, kreg=K1. Enter FIN.
- FIN (1 cycle):
  - odat <= dreg ^ kreg[79:16]; done=1; busy=0; next state IDLE.
- Latency:
  - load sampled at edge T → done=1 and odat valid after edge T+2*NR+1 (edge T+63 for NR=31).
  - Total 63 cycles, fully deterministic.
- done:
  - High exactly one cycle per completed operation.
  - Never asserted for an aborted operation.
  - A load coincident with FIN takes priority: odat cleared, no done.
- odat holds its value until the next accepted load or reset.
- Inverse pLayer: bit j of the output takes bit P(j) of the input, where P(j) = 16*j mod 63 for j<63 and P(63)=63.
- Inverse S-box: inverse of C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2, giving 5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A.
- Round counter: 5-bit, no wrap-around reachable for NR<=31.
- idat and key are don't-care except in the load cycle.

Test Plan:
- Known answer: key=0, idat=5579C1387B228445, load → after 63 cycles done=1, odat=0000000000000000.
- Known answer: key=FFFFFFFFFFFFFFFFFFFF, idat=E72C46C0F5945049 → odat=0000000000000000. Also key=0, idat=A112FFC72F68417B → odat=FFFFFFFFFFFFFFFF.
- Known answer: key=all ones, idat=3333DCD3213210D2 → odat=FFFFFFFFFFFFFFFF. Check busy=1 for exactly 63 cycles, done for exactly 1 cycle, and odat stable for 10 cycles after.
- Restart: load vector A, then load vector B 20 cycles later → single done 63 cycles after B's load with B's plaintext; no done for A.
- Async reset asserted mid-DEC (cycle 40) → odat=0, done=0, busy=0 immediately. A fresh load then completes normally with the correct result.
- Round-trip: 1000 random (key, plaintext) pairs, encrypted with the encryption core or a reference model → decrypted output equals the plaintext. Include a back-to-back load on the cycle after done.

Source files
------------

// File: rtl/present80_dec.sv
// -----------------------------------------------------------------------------
// present80_dec
//
// PRESENT-80 block decryption core, one round per clock.
//
// The key schedule is computed on the fly: after a load the core first runs
// the forward key update NR times to reach the last round key K(NR+1). It then
// decrypts, walking the schedule backwards one step per round, and finally
// whitens with K1.
//
// Operation sequence: IDLE -> KEYEXP (NR cycles) -> DEC (NR cycles)
// -> FIN (1 cycle) -> IDLE.
// A load sampled at edge T gives done/odat at edge T + 2*NR + 1.
//
// Ports:
//   clk    in   1   rising-edge clock
//   reset  in   1   asynchronous, active-high reset
//   idat   in  64   ciphertext, sampled on load
//   key    in  80   cipher key, sampled on load
//   load   in   1   start request; accepted in any state (aborts a running op)
//   odat   out 64   plaintext, valid with done and held until next load/reset
//   done   out  1   one-cycle pulse when odat is updated
//   busy   out  1   high from the cycle after an accepted load until done
// -----------------------------------------------------------------------------
module present80_dec #(
  parameter int NR = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] idat,
  input  logic [79:0] key,
  input  logic        load,
  output logic [63:0] odat,
  output logic        done,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_KEYEXP = 2'd1;
  localparam logic [1:0] ST_DEC    = 2'd2;
  localparam logic [1:0] ST_FIN    = 2'd3;

  localparam logic [4:0] NR_RC = 5'(NR);

  // Forward PRESENT S-box.
  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0:    y = 4'hC;
      4'h1:    y = 4'h5;
      4'h2:    y = 4'h6;
      4'h3:    y = 4'hB;
      4'h4:    y = 4'h9;
      4'h5:    y = 4'h0;
      4'h6:    y = 4'hA;
      4'h7:    y = 4'hD;
      4'h8:    y = 4'h3;
      4'h9:    y = 4'hE;
      4'hA:    y = 4'hF;
      4'hB:    y = 4'h8;
      4'hC:    y = 4'h4;
      4'hD:    y = 4'h7;
      4'hE:    y = 4'h1;
      4'hF:    y = 4'h2;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

  // Inverse PRESENT S-box.
  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0:    y = 4'h5;
      4'h1:    y = 4'hE;
      4'h2:    y = 4'hF;
      4'h3:    y = 4'h8;
      4'h4:    y = 4'hC;
      4'h5:    y = 4'h1;
      4'h6:    y = 4'h2;
      4'h7:    y = 4'hD;
      4'h8:    y = 4'hB;
      4'h9:    y = 4'h4;
      4'hA:    y = 4'h6;
      4'hB:    y = 4'h3;
      4'hC:    y = 4'h0;
      4'hD:    y = 4'h7;
      4'hE:    y = 4'h9;
      4'hF:    y = 4'hA;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

  // Inverse S-box applied to all 16 nibbles.
  function automatic logic [63:0] inv_sbox_layer(input logic [63:0] d);
    logic [63:0] o;
    o = 64'd0;
    for (int n = 0; n < 16; n++) begin
      o[4*n +: 4] = inv_sbox(d[4*n +: 4]);
    end
    return o;
  endfunction

  // Inverse pLayer: output bit j takes input bit 16*j mod 63; bit 63 is fixed.
  function automatic logic [63:0] inv_player(input logic [63:0] d);
    logic [63:0] o;
    o = d;
    for (int j = 0; j < 63; j++) begin
      o[j] = d[(16 * j) % 63];
    end
    o[63] = d[63];
    return o;
  endfunction

  // Forward key update: K(i) -> K(i+1) using round counter i.
  function automatic logic [79:0] key_fwd(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] t;
    t          = {k[18:0], k[79:19]};          // rotate left by 61
    t[79:76]   = sbox(t[79:76]);
    t[19:15]   = t[19:15] ^ rc;
    return t;
  endfunction

  // Inverse key update: K(i+1) -> K(i) using round counter i (steps undone in reverse order).
  function automatic logic [79:0] key_inv(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] t;
    t          = k;
    t[19:15]   = t[19:15] ^ rc;
    t[79:76]   = inv_sbox(t[79:76]);
    return {t[60:0], t[79:61]};                // rotate right by 61
  endfunction

  logic [1:0]  state_r;
  logic [79:0] kreg_r;
  logic [63:0] dreg_r;
  logic [4:0]  rc_r;

  logic [79:0] kfwd_s;
  logic [79:0] kinv_s;
  logic [63:0] dec_next_s;
  logic [63:0] whiten_s;

  // Round datapath: next key (both directions) and one inverse round.
  always_comb begin
    kfwd_s     = key_fwd(kreg_r, rc_r);
    kinv_s     = key_inv(kreg_r, rc_r);
    whiten_s   = dreg_r ^ kreg_r[79:16];
    dec_next_s = inv_sbox_layer(inv_player(whiten_s));
  end

  // Control FSM, round registers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      kreg_r  <= 80'd0;
      dreg_r  <= 64'd0;
      rc_r    <= 5'd0;
      odat    <= 64'd0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else if (load) begin
      // A load wins over everything, including the FIN cycle of a running op.
      state_r <= ST_KEYEXP;
      kreg_r  <= key;
      dreg_r  <= idat;
      rc_r    <= 5'd1;
      odat    <= 64'd0;
      done    <= 1'b0;
      busy    <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
        end
        ST_KEYEXP: begin
          done   <= 1'b0;
          kreg_r <= kfwd_s;
          // rc stays at NR on the last expansion step so DEC starts from it.
          if (rc_r == NR_RC) begin
            state_r <= ST_DEC;
          end else begin
            rc_r <= rc_r + 5'd1;
          end
        end
        ST_DEC: begin
          done   <= 1'b0;
          dreg_r <= dec_next_s;
          kreg_r <= kinv_s;
          rc_r   <= rc_r - 5'd1;
          if (rc_r == 5'd1) begin
            state_r <= ST_FIN;
          end else begin
            state_r <= ST_DEC;
          end
        end
        ST_FIN: begin
          // kreg holds K1 here: final whitening.
          odat    <= whiten_s;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
